// File: rtl/ysyx_041514_lsu_memif.sv
// LSU memory interface: latches one load/store, aligns it onto a 64-bit bus,
// and returns right-justified load data to the sign-extension stage.
module ysyx_041514_lsu_memif (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_load,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [3:0]  in_size,
    input  logic        in_signed,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [63:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [3:0]  out_size,
    output logic        out_signed,
    output logic        out_misalign
);

    localparam int unsigned XLEN = 64;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              load_q;
    logic              signed_q;
    logic              misalign_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   data_q;
    logic [3:0]        size_q;
    logic [2:0]        off;
    logic [5:0]        shamt;
    logic [7:0]        strb_base;
    logic              accept;
    logic              misalign_in;

    assign off    = addr_q[2:0];
    assign shamt  = {off, 3'b000};
    assign accept = in_valid && in_ready;

    // Alignment is judged on the incoming op so a bad access never reaches REQ.
    assign misalign_in = (in_size[1] && in_addr[0])
                      || (in_size[2] && (in_addr[1:0] != 2'b00))
                      || (in_size[3] && (in_addr[2:0] != 3'b000));

    always_comb begin
        state_d       = state_q;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        out_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_d = misalign_in ? DONE : REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                mem_rsp_ready = 1'b1;
                if (mem_rsp_valid) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        strb_base = 8'h01;
        if (size_q[3])      strb_base = 8'hFF;
        else if (size_q[2]) strb_base = 8'h0F;
        else if (size_q[1]) strb_base = 8'h03;
    end

    assign mem_addr     = {addr_q[XLEN-1:3], 3'b000};
    assign mem_we       = !load_q;
    assign mem_wdata    = wdata_q << shamt;
    assign mem_wstrb    = load_q ? 8'h00 : (strb_base << off);
    assign out_data     = data_q;
    assign out_size     = size_q;
    assign out_signed   = signed_q;
    assign out_misalign = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            load_q     <= 1'b0;
            signed_q   <= 1'b0;
            misalign_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            size_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                load_q     <= in_load;
                signed_q   <= in_signed;
                misalign_q <= misalign_in;
                addr_q     <= in_addr;
                wdata_q    <= in_wdata;
                size_q     <= in_size;
                data_q     <= '0;
            end
            if (state_q == WAIT && mem_rsp_valid) begin
                data_q <= load_q ? (mem_rdata >> shamt) : '0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_041514_lsu_memif.sv
// Bench for ysyx_041514_lsu_memif: directed and randomized ops against a
// byte-arithmetic reference model with a cycle-by-cycle bus/consumer model.
module tb_ysyx_041514_lsu_memif;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_load, in_signed;
    logic [63:0] in_addr, in_wdata;
    logic [3:0]  in_size;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic        out_valid, out_ready, out_signed, out_misalign;
    logic [63:0] out_data;
    logic [3:0]  out_size;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_041514_lsu_memif dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size), .in_signed(in_signed),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_size(out_size), .out_signed(out_signed), .out_misalign(out_misalign)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Byte-level view: nb bytes at offset off within the 8-byte word.
    function automatic void ref_model(input logic ld, input logic [63:0] a, input logic [63:0] wd,
                                      input logic [63:0] rd, input logic [3:0] sz,
                                      output logic mis, output logic [63:0] maddr,
                                      output logic [63:0] mwdata, output logic [63:0] odata,
                                      output logic [7:0] strb);
        int unsigned nb, off;
        nb     = sz[3] ? 8 : sz[2] ? 4 : sz[1] ? 2 : 1;
        off    = int'(a[2:0]);
        mis    = (off % nb) != 0;
        maddr  = a - 64'(off);
        mwdata = wd << (8 * off);
        strb   = ld ? 8'h00 : 8'(((1 << nb) - 1) << off);
        odata  = (mis || !ld) ? 64'd0 : (rd >> (8 * off));
    endfunction

    task automatic scramble_inputs();
        in_valid  = 1'($urandom % 2);
        in_load   = 1'($urandom % 2);
        in_addr   = {$urandom, $urandom};
        in_wdata  = {$urandom, $urandom};
        in_size   = 4'($urandom);
        in_signed = 1'($urandom % 2);
    endtask

    task automatic run_op(input logic ld, input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] rd, input logic [3:0] sz, input logic sg,
                          input int req_dly, input int rsp_dly, input int out_dly,
                          input bit chk_lat);
        logic        mis;
        logic [63:0] e_addr, e_wdata, e_odata;
        logic [7:0]  e_strb;
        int          phase, cnt, reqs, first_out;
        bit          done;
        ref_model(ld, a, wd, rd, sz, mis, e_addr, e_wdata, e_odata, e_strb);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_load = ld; in_addr = a; in_wdata = wd;
        in_size = sz; in_signed = sg;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        phase = mis ? 2 : 0; cnt = 0; reqs = 0; first_out = -1; done = 0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            scramble_inputs();
            mem_req_ready = (phase == 0) ? (cnt >= req_dly) : 1'($urandom % 2);
            mem_rsp_valid = (phase == 1) ? (cnt >= rsp_dly) : 1'($urandom % 2);
            mem_rdata     = (phase == 1 && cnt >= rsp_dly) ? rd : {$urandom, $urandom};
            out_ready     = (phase == 2) ? (cnt >= out_dly) : 1'($urandom % 2);
            @(negedge clk);
            check("in_ready_busy", 64'(in_ready), 64'd0);
            if (phase == 0) begin
                check("req_valid", 64'(mem_req_valid), 64'd1);
                check("mem_addr", mem_addr, e_addr);
                check("mem_we", 64'(mem_we), 64'(!ld));
                check("mem_wstrb", 64'(mem_wstrb), 64'(e_strb));
                check("mem_wdata", mem_wdata, e_wdata);
                check("rsp_ready_req", 64'(mem_rsp_ready), 64'd0);
                check("out_valid_req", 64'(out_valid), 64'd0);
                if (mem_req_valid && mem_req_ready) begin
                    reqs++; phase = 1; cnt = 0;
                end else cnt++;
            end else if (phase == 1) begin
                check("req_valid_wait", 64'(mem_req_valid), 64'd0);
                check("rsp_ready_wait", 64'(mem_rsp_ready), 64'd1);
                check("out_valid_wait", 64'(out_valid), 64'd0);
                if (mem_rsp_valid) begin
                    phase = 2; cnt = 0;
                end else cnt++;
            end else begin
                if (first_out < 0) first_out = cyc;
                check("out_valid", 64'(out_valid), 64'd1);
                check("out_data", out_data, e_odata);
                check("out_size", 64'(out_size), 64'(sz));
                check("out_signed", 64'(out_signed), 64'(sg));
                check("out_misalign", 64'(out_misalign), 64'(mis));
                check("req_valid_done", 64'(mem_req_valid), 64'd0);
                check("rsp_ready_done", 64'(mem_rsp_ready), 64'd0);
                if (out_ready) done = 1; else cnt++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; out_ready = 1'b0;
        check("op_completed", 64'(done), 64'd1);
        check("req_count", 64'(reqs), mis ? 64'd0 : 64'd1);
        if (chk_lat) check("latency", 64'(first_out), mis ? 64'd0 : 64'd2);
    endtask

    initial begin
        logic [63:0] a;
        logic [3:0]  sz;
        rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_addr = '0; in_wdata = '0;
        in_size = '0; in_signed = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rdata = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_rsp_ready", 64'(mem_rsp_ready), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases: byte load, word store, misaligned load, back-pressure.
        run_op(1'b1, 64'h8000_0005, 64'h0, 64'h1122_3344_5566_7788, 4'b0001, 1'b1, 0, 0, 0, 1);
        run_op(1'b0, 64'h8000_0004, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 1'b0, 0, 0, 0, 1);
        run_op(1'b1, 64'h8000_0002, 64'h0, 64'h0123_4567_89AB_CDEF, 4'b1000, 1'b0, 0, 0, 0, 1);
        run_op(1'b1, 64'h8000_0006, 64'h0, 64'hA5A5_0000_5A5A_FFFF, 4'b0010, 1'b1, 5, 3, 2, 0);

        // Reset while waiting for a response, then a stray late response.
        check("in_ready_pre_rst", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_load = 1'b1; in_addr = 64'h8000_0010;
        in_size = 4'b1000; in_signed = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        check("wait_rsp_ready", 64'(mem_rsp_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_out_size", 64'(out_size), 64'd0);
        check("rst2_out_signed", 64'(out_signed), 64'd0);
        check("rst2_out_misalign", 64'(out_misalign), 64'd0);
        check("rst2_rsp_ready", 64'(mem_rsp_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'hCAFE_F00D_1234_5678;
        repeat (3) begin
            @(negedge clk);
            check("stray_out_valid", 64'(out_valid), 64'd0);
            check("stray_rsp_ready", 64'(mem_rsp_ready), 64'd0);
            check("stray_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0;
        run_op(1'b1, 64'h8000_0010, 64'h0, 64'h0BAD_BEEF_0000_1111, 4'b1000, 1'b1, 0, 0, 0, 1);

        for (int i = 0; i < 60; i++) begin
            sz = 4'b0001 << $urandom_range(0, 3);
            a  = {$urandom, $urandom};
            if ($urandom % 3 != 0)
                a[2:0] = a[2:0] & ~(sz[3] ? 3'd7 : sz[2] ? 3'd3 : sz[1] ? 3'd1 : 3'd0);
            run_op(1'($urandom % 2), a, {$urandom, $urandom}, {$urandom, $urandom}, sz,
                   1'($urandom % 2), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
